// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched
// Round-robin write arbiter and paced read controller that shares one external
// DEPTH-entry FIFO (registered read port) between NUM_REQ producer streams and
// drains it to a single valid/ready consumer.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-low (0 = reset)
//   req_valid      per-producer "word available"
//   req_data       producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      one-hot accept, word taken when req_valid[i] & req_ready[i]
//   fifo_wr_req    FIFO write strobe
//   fifo_data_in   FIFO write data
//   fifo_rd_req    FIFO read strobe (one cycle per word)
//   fifo_data_out  FIFO read register output
//   fifo_full      FIFO full flag
//   fifo_empty     FIFO empty flag
//   out_valid      consumer word valid
//   out_data       consumer word
//   out_ready      consumer accept
//   level          words currently held in the FIFO (0..DEPTH)
//   grant_id       index of the last accepted producer
module fifo_rr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int PTR_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_req,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_rd_req,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH:0]           level,
  output logic [PTR_WIDTH-1:0]          grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_READ,
    ST_HOLD
  } rd_state_t;

  localparam logic [ADDR_WIDTH:0] LEVEL_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]  NUM_REQ_W = (PTR_WIDTH+1)'(NUM_REQ);
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_REQ - 1);

  logic [PTR_WIDTH-1:0]  r_rr_ptr;
  logic [PTR_WIDTH-1:0]  r_grant_id;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  rd_state_t             r_state;
  rd_state_t             w_state_next;

  logic [PTR_WIDTH-1:0]  w_idx [NUM_REQ];
  logic [PTR_WIDTH-1:0]  w_win;
  logic                  w_any;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [PTR_WIDTH-1:0]  w_ptr_next;

  // w_idx[k] is the producer examined k-th, starting at the round-robin
  // pointer and wrapping modulo NUM_REQ (NUM_REQ need not be a power of 2).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      logic [PTR_WIDTH:0] w_sum;
      assign w_sum = {1'b0, r_rr_ptr} + (PTR_WIDTH+1)'(gi);
      assign w_idx[gi] = (w_sum >= NUM_REQ_W) ? PTR_WIDTH'(w_sum - NUM_REQ_W)
                                              : PTR_WIDTH'(w_sum);
      assign req_ready[gi] = w_wr_en && (w_win == PTR_WIDTH'(gi));
    end
  endgenerate

  // Scan from the last search position down to the first so the earliest
  // valid producer in round-robin order is the one left in w_win.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_idx[k]]) begin
        w_any = 1'b1;
        w_win = w_idx[k];
      end
    end
  end

  // Both the FIFO flag and the local level must allow the write.
  assign w_wr_en      = rst && w_any && !fifo_full && (r_level < LEVEL_MAX);
  assign fifo_wr_req  = w_wr_en;
  assign fifo_data_in = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign w_ptr_next   = (w_win == LAST_IDX) ? '0 : w_win + PTR_WIDTH'(1);

  // Read FSM: SETTLE gives the FIFO read register one cycle to present the
  // head word before it is captured in READ.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      ST_IDLE:   if (!fifo_empty) w_state_next = ST_SETTLE;
      ST_SETTLE: w_state_next = fifo_empty ? ST_IDLE : ST_READ;
      ST_READ: begin
        w_rd_en      = rst;
        w_state_next = ST_HOLD;
      end
      ST_HOLD:   if (out_ready) w_state_next = fifo_empty ? ST_IDLE : ST_SETTLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign fifo_rd_req = w_rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_en) begin
        r_rr_ptr   <= w_ptr_next;
        r_grant_id <= w_win;
      end
      // A write and a read in the same cycle cancel out.
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + (ADDR_WIDTH+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_WIDTH+1)'(1);
        default: r_level <= r_level;
      endcase
      if (r_state == ST_READ) begin
        r_out_valid <= 1'b1;
        r_out_data  <= fifo_data_out;
      end else if ((r_state == ST_HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // The write and read guards make level overflow/underflow unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_wr_en && !w_rd_en && (r_level == LEVEL_MAX)));
      assert (!(w_rd_en && !w_wr_en && (r_level == '0)));
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = r_level;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched
// Self-checking bench for fifo_rr_sched. A behavioural FIFO with a registered
// read port stands in for the shared FIFO. A reference model (round-robin
// search by modular arithmetic, word-count level, write-order queue for the
// consumer side) is checked every cycle; directed scenarios cover reset,
// round robin to full, first-word latency, backpressure, simultaneous
// write/read and reset during HOLD, followed by randomized traffic.
module tb_fifo_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_wr_req;
  logic [DW-1:0]        fifo_data_in;
  logic                 fifo_rd_req;
  logic [DW-1:0]        fifo_data_out;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_ready;
  logic [2:0]           level;
  logic [1:0]           grant_id;

  always #5 clk = ~clk;

  fifo_rr_sched #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_req(fifo_wr_req),
    .fifo_data_in(fifo_data_in),
    .fifo_rd_req(fifo_rd_req),
    .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .level(level),
    .grant_id(grant_id)
  );

  // Behavioural FIFO: registered read port, flags from the word count.
  logic [DW-1:0] f_mem [DEPTH];
  int            f_wp;
  int            f_rp;
  int            f_cnt;
  logic [DW-1:0] f_dout;

  always @(posedge clk) begin
    if (!rst) begin
      f_wp   <= 0;
      f_rp   <= 0;
      f_cnt  <= 0;
      f_dout <= '0;
    end else begin
      f_dout <= f_mem[f_rp];
      if (fifo_wr_req && f_cnt < DEPTH) begin
        f_mem[f_wp] <= fifo_data_in;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      if (fifo_rd_req && f_cnt > 0) f_rp <= (f_rp + 1) % DEPTH;
      f_cnt <= f_cnt + ((fifo_wr_req && f_cnt < DEPTH) ? 1 : 0)
                     - ((fifo_rd_req && f_cnt > 0) ? 1 : 0);
    end
  end

  assign fifo_full     = (f_cnt == DEPTH);
  assign fifo_empty    = (f_cnt == 0);
  assign fifo_data_out = f_dout;

  // Reference model state
  int            m_ptr;
  int            m_level;
  int            m_grant;
  logic [DW-1:0] m_q[$];
  int            cyc;
  int            last_rd;
  bit            prev_hold;
  logic [DW-1:0] prev_data;

  // Values observed during the most recent cycle
  logic [NUM_REQ-1:0] s_req_ready;
  logic               s_wr;
  logic               s_rd;

  int n_vec;
  int n_mis;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already applied by the caller.
  task automatic tick();
    int                 exp_win;
    logic [NUM_REQ-1:0] exp_ready;
    logic [DW-1:0]      exp_word;
    bit                 in_rst;
    #1;
    in_rst      = !rst;
    s_req_ready = req_ready;
    s_wr        = fifo_wr_req;
    s_rd        = fifo_rd_req;

    exp_win = -1;
    if (!in_rst && m_level < DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (exp_win < 0 && req_valid[idx]) exp_win = idx;
      end
    end
    exp_ready = '0;
    if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
    check_val("req_ready", req_ready, exp_ready);
    check_val("fifo_wr_req", fifo_wr_req, exp_win >= 0);
    if (exp_win >= 0) check_val("fifo_data_in", fifo_data_in, req_data[exp_win*DW +: DW]);

    if (in_rst) begin
      check_val("rd_in_reset", fifo_rd_req, 1'b0);
    end else if (fifo_rd_req) begin
      check_val("rd_on_empty", m_level == 0, 1'b0);
      if (last_rd >= 0) check_val("rd_spacing", (cyc - last_rd) >= 3, 1'b1);
    end

    if (prev_hold) begin
      check_val("hold_valid", out_valid, 1'b1);
      check_val("hold_data", out_data, prev_data);
    end

    if (!in_rst && out_valid && out_ready) begin
      check_val("pop_has_word", m_q.size() > 0, 1'b1);
      if (m_q.size() > 0) begin
        exp_word = m_q.pop_front();
        check_val("out_word", out_data, exp_word);
      end
    end
    prev_hold = !in_rst && out_valid && !out_ready;
    prev_data = out_data;

    @(posedge clk);
    if (in_rst) begin
      m_ptr   = 0;
      m_level = 0;
      m_grant = 0;
      m_q.delete();
      last_rd = -1;
    end else begin
      if (exp_win >= 0) begin
        m_q.push_back(req_data[exp_win*DW +: DW]);
        m_ptr   = (exp_win + 1) % NUM_REQ;
        m_grant = exp_win;
        m_level++;
      end
      if (s_rd) begin
        m_level--;
        last_rd = cyc;
      end
    end
    cyc++;
    #2;
    check_val("level", level, m_level);
    check_val("grant_id", grant_id, m_grant);
    if (in_rst) begin
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_out_data", out_data, '0);
    end
  endtask

  // Empty everything and leave the read FSM idle.
  task automatic drain();
    int idle;
    bit done;
    req_valid = '0;
    out_ready = 1'b1;
    idle = 0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (level == 0 && !out_valid && !fifo_rd_req) idle++;
      else idle = 0;
      if (idle >= 3) begin
        done = 1'b1;
        break;
      end
    end
    check_val("drain_done", done, 1'b1);
  endtask

  task automatic rand_data();
    req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_rd;
    int rd_t[$];
    bit seen;
    logic [DW-1:0] w0;

    n_vec = 0; n_mis = 0; cyc = 0; last_rd = -1;
    m_ptr = 0; m_level = 0; m_grant = 0;
    prev_hold = 1'b0; prev_data = '0;
    rst = 1'b0; req_valid = '1; out_ready = 1'b0;
    rand_data();

    // Reset held with all producers valid
    tick();
    tick();
    check_val("rst_req_ready", s_req_ready, '0);
    check_val("rst_wr", s_wr, 1'b0);
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_level", level, '0);

    // Round robin from port 0 until the FIFO fills
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [NUM_REQ-1:0] exp_oh;
      rand_data();
      tick();
      exp_oh = '0;
      exp_oh[i] = 1'b1;
      check_val("rr_order", s_req_ready, exp_oh);
    end
    for (int i = 0; i < 6; i++) begin
      rand_data();
      tick();
    end
    check_val("full_level", level, 3'd4);
    check_val("full_wr", s_wr, 1'b0);
    check_val("full_ready", s_req_ready, '0);
    check_val("full_flag", fifo_full, 1'b1);

    // First-word latency through an empty FIFO
    drain();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hA5A5_0001;
    tick();
    check_val("lat_grant", s_req_ready, 4'b0100);
    req_valid = '0;
    tick();
    check_val("lat_rd_c1", s_rd, 1'b0);
    tick();
    check_val("lat_rd_c2", s_rd, 1'b0);
    tick();
    check_val("lat_rd_c3", s_rd, 1'b1);
    check_val("lat_valid", out_valid, 1'b1);
    check_val("lat_data", out_data, 32'hA5A5_0001);
    check_val("lat_level", level, '0);
    tick();

    // Backpressure: three words, consumer stalled
    drain();
    out_ready = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b1000;
      req_data[3*DW +: DW] = 32'hB000_0000 + i;
      tick();
      n_rd += int'(s_rd);
    end
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_rd += int'(s_rd);
    end
    check_val("bp_rd_count", n_rd, 1);
    check_val("bp_valid", out_valid, 1'b1);
    check_val("bp_data", out_data, 32'hB000_0000);
    check_val("bp_level", level, 3'd2);
    out_ready = 1'b1;
    rd_t.delete();
    for (int i = 0; i < 30 && rd_t.size() < 2; i++) begin
      tick();
      if (s_rd) rd_t.push_back(cyc);
    end
    check_val("bp_rd_seen", rd_t.size(), 2);
    if (rd_t.size() == 2) check_val("bp_rd_gap", rd_t[1] - rd_t[0], 3);
    drain();

    // Write on port 1 in the same cycle as a READ with level 2
    out_ready = 1'b1;
    w0 = $urandom;
    req_valid = 4'b0001;
    req_data[0 +: DW] = w0;
    tick();
    req_data[0 +: DW] = $urandom;
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_val("sim_read_seen", seen, 1'b1);
    check_val("sim_level_pre", level, 3'd2);
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = $urandom;
    tick();
    req_valid = '0;
    check_val("sim_wr", s_wr, 1'b1);
    check_val("sim_rd", s_rd, 1'b1);
    check_val("sim_level", level, 3'd2);
    check_val("sim_older_word", out_data, w0);
    drain();

    // Reset while holding a word with three more queued
    out_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      tick();
    end
    req_valid = '0;
    tick();
    check_val("mid_valid_pre", out_valid, 1'b1);
    check_val("mid_level_pre", level, 3'd3);
    rst = 1'b0;
    tick();
    check_val("mid_rd_in_rst", s_rd, 1'b0);
    check_val("mid_valid", out_valid, 1'b0);
    check_val("mid_level", level, '0);
    rst = 1'b1;
    n_rd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_rd += int'(s_rd);
    end
    check_val("mid_no_rd", n_rd, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      req_valid = NUM_REQ'($urandom);
      rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst = 1'b1;
    drain();
    check_val("final_queue", m_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
